// File: rtl/led_pattern_gen.sv
//------------------------------------------------------------------------------
// led_pattern_gen
//    Multi-channel LED pattern generator driven by one shared frame timer.
//    A frame is NSLOTS slots of slot_len_q cycles. Each channel selects off,
//    on, heartbeat (pulses in slots 1..npulse_q) or activity (trigger-stretched
//    flash). Timing inputs are shadowed and only load at the frame end.
//
// Ports:
//    clk          system clock
//    rst_n        asynchronous active-low reset
//    mode_i       2 bits per channel: 00 off, 01 on, 10 heartbeat, 11 activity
//    trig_i       per-channel activity strobe
//    slot_len_i   requested slot length (values < 2 are ignored)
//    pulse_len_i  requested pulse / stretch length
//    npulse_i     requested heartbeat pulses per frame
//    led_o        registered LED drive (inverted when ACTIVE_LOW != 0)
//    frame_tick_o one-cycle pulse on the cycle after each frame end
//------------------------------------------------------------------------------
module led_pattern_gen #(
   parameter int unsigned N_LEDS     = 8,
   parameter int unsigned CNT_W      = 29,
   parameter int unsigned NSLOTS     = 4,
   parameter int unsigned SLOT_LEN   = 31250000,
   parameter int unsigned PULSE_LEN  = 3125000,
   parameter int unsigned NPULSE     = 3,
   parameter int unsigned ACTIVE_LOW = 0,
   localparam int unsigned IDX_W     = $clog2(NSLOTS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [2*N_LEDS-1:0]   mode_i,
   input  logic [N_LEDS-1:0]     trig_i,
   input  logic [CNT_W-1:0]      slot_len_i,
   input  logic [CNT_W-1:0]      pulse_len_i,
   input  logic [IDX_W-1:0]      npulse_i,
   output logic [N_LEDS-1:0]     led_o,
   output logic                  frame_tick_o
);

   localparam logic             INV      = (ACTIVE_LOW != 0);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLOTS - 1);

   logic [CNT_W-1:0]  slot_cnt_q,  slot_cnt_d;
   logic [IDX_W-1:0]  slot_idx_q,  slot_idx_d;
   logic [CNT_W-1:0]  slot_len_q,  slot_len_d;
   logic [CNT_W-1:0]  pulse_len_q, pulse_len_d;
   logic [IDX_W-1:0]  npulse_q,    npulse_d;
   logic [CNT_W-1:0]  stretch_q [N_LEDS];
   logic [CNT_W-1:0]  stretch_d [N_LEDS];
   logic [N_LEDS-1:0] led_q,       led_d;
   logic              tick_q,      tick_d;

   logic              slot_end;
   logic              frame_end;
   logic              hb;
   logic [N_LEDS-1:0] act;

   // Frame timer and shadow registers
   always_comb begin
      slot_end    = (slot_cnt_q == slot_len_q - 1'b1);
      frame_end   = slot_end && (slot_idx_q == LAST_IDX);
      slot_cnt_d  = slot_end ? '0 : slot_cnt_q + 1'b1;
      // NSLOTS is a power of two, so the index wraps naturally
      slot_idx_d  = slot_end ? slot_idx_q + 1'b1 : slot_idx_q;
      slot_len_d  = slot_len_q;
      pulse_len_d = pulse_len_q;
      npulse_d    = npulse_q;
      if (frame_end) begin
         // A slot shorter than 2 cycles would make slot_len_q-1 degenerate
         if (slot_len_i >= CNT_W'(2)) begin
            slot_len_d = slot_len_i;
         end
         pulse_len_d = pulse_len_i;
         npulse_d    = npulse_i;
      end
      tick_d = frame_end;
   end

   // Heartbeat condition, shared by all channels so they stay phase-aligned
   always_comb begin
      hb = (slot_idx_q != '0) && (slot_idx_q <= npulse_q) &&
           (slot_cnt_q < pulse_len_q);
   end

   // Per-channel stretch counters and output select
   always_comb begin
      act   = '0;
      led_d = '0;
      for (int unsigned i = 0; i < N_LEDS; i++) begin
         act[i] = (stretch_q[i] != '0) || trig_i[i];
         if (trig_i[i]) begin
            stretch_d[i] = pulse_len_q;
         end else if (stretch_q[i] != '0) begin
            stretch_d[i] = stretch_q[i] - 1'b1;
         end else begin
            stretch_d[i] = stretch_q[i];
         end
         case (mode_i[2*i +: 2])
            2'b00:   led_d[i] = 1'b0 ^ INV;
            2'b01:   led_d[i] = 1'b1 ^ INV;
            2'b10:   led_d[i] = hb ^ INV;
            default: led_d[i] = act[i] ^ INV;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt_q  <= '0;
         slot_idx_q  <= '0;
         slot_len_q  <= CNT_W'(SLOT_LEN);
         pulse_len_q <= CNT_W'(PULSE_LEN);
         npulse_q    <= IDX_W'(NPULSE);
         for (int unsigned i = 0; i < N_LEDS; i++) begin
            stretch_q[i] <= '0;
         end
         led_q       <= {N_LEDS{INV}};
         tick_q      <= 1'b0;
      end else begin
         slot_cnt_q  <= slot_cnt_d;
         slot_idx_q  <= slot_idx_d;
         slot_len_q  <= slot_len_d;
         pulse_len_q <= pulse_len_d;
         npulse_q    <= npulse_d;
         for (int unsigned i = 0; i < N_LEDS; i++) begin
            stretch_q[i] <= stretch_d[i];
         end
         led_q       <= led_d;
         tick_q      <= tick_d;
      end
   end

   assign led_o        = led_q;
   assign frame_tick_o = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
module tb_led_pattern_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] mode_i = '0;
   logic [7:0]  trig_i = '0;
   logic [28:0] slot_len_i = 29'd10;
   logic [28:0] pulse_len_i = 29'd3;
   logic [1:0]  npulse_i = 2'd3;
   logic [7:0]  led0, led1;
   logic        tick0, tick1;

   always #5 clk = ~clk;

   led_pattern_gen #(
      .N_LEDS(8), .CNT_W(29), .NSLOTS(4), .SLOT_LEN(10), .PULSE_LEN(3),
      .NPULSE(3), .ACTIVE_LOW(0)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .trig_i(trig_i),
      .slot_len_i(slot_len_i), .pulse_len_i(pulse_len_i), .npulse_i(npulse_i),
      .led_o(led0), .frame_tick_o(tick0)
   );

   led_pattern_gen #(
      .N_LEDS(8), .CNT_W(29), .NSLOTS(4), .SLOT_LEN(10), .PULSE_LEN(3),
      .NPULSE(3), .ACTIVE_LOW(1)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .trig_i(trig_i),
      .slot_len_i(slot_len_i), .pulse_len_i(pulse_len_i), .npulse_i(npulse_i),
      .led_o(led1), .frame_tick_o(tick1)
   );

   // Hand-computed expectations: ch 0-7 = dut0 led bit, 8 = dut0 tick,
   // 16-23 = active-low dut1 led bit
   typedef struct {
      int   scen;
      int   cyc;
      int   ch;
      logic exp;
   } chk_t;
   chk_t tbl[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int cur_scen = 0;

   // Reference model state
   int unsigned m_cnt, m_idx, m_sl, m_pl, m_np;
   int unsigned m_st [8];
   logic [7:0]  m_led;
   logic        m_tick;

   task automatic add(input int s, input int c, input int ch, input logic e);
      chk_t t;
      t.scen = s; t.cyc = c; t.ch = ch; t.exp = e;
      tbl.push_back(t);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s scen=%0d cyc=%0d actual=%0h required=%0h",
                  name, cur_scen, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_idx = 0; m_sl = 10; m_pl = 3; m_np = 3;
      for (int i = 0; i < 8; i++) m_st[i] = 0;
      m_led = '0; m_tick = 1'b0;
   endtask

   task automatic model_step();
      logic       hb, act, fe;
      logic [7:0] nl;
      hb = (m_idx >= 1) && (m_idx <= m_np) && (m_cnt < m_pl);
      for (int i = 0; i < 8; i++) begin
         act = (m_st[i] != 0) || trig_i[i];
         case (mode_i[2*i +: 2])
            2'b00:   nl[i] = 1'b0;
            2'b01:   nl[i] = 1'b1;
            2'b10:   nl[i] = hb;
            default: nl[i] = act;
         endcase
      end
      fe = (m_idx == 3) && (m_cnt == m_sl - 1);
      m_led  = nl;
      m_tick = fe;
      for (int i = 0; i < 8; i++) begin
         if (trig_i[i]) m_st[i] = m_pl;
         else if (m_st[i] != 0) m_st[i] = m_st[i] - 1;
      end
      if (m_cnt == m_sl - 1) begin
         m_cnt = 0;
         m_idx = (m_idx + 1) % 4;
      end else begin
         m_cnt = m_cnt + 1;
      end
      if (fe) begin
         if (slot_len_i >= 2) m_sl = slot_len_i;
         m_pl = pulse_len_i;
         m_np = npulse_i;
      end
   endtask

   // Called half a period before edge 'cyc': outputs now are cycle 'cyc'
   task automatic check_now();
      logic [7:0] inv;
      logic       a;
      inv = ~m_led;
      chk("led_o", led0, m_led);
      chk("led_o_al", led1, inv);
      chk("frame_tick", tick0, m_tick);
      chk("frame_tick_al", tick1, m_tick);
      foreach (tbl[k]) begin
         if (tbl[k].scen == cur_scen && tbl[k].cyc == cyc) begin
            if (tbl[k].ch < 8)       a = led0[tbl[k].ch];
            else if (tbl[k].ch == 8) a = tick0;
            else                     a = led1[tbl[k].ch - 16];
            chk($sformatf("tbl_ch%0d", tbl[k].ch), a, tbl[k].exp);
         end
      end
   endtask

   task automatic stim();
      case (cur_scen)
         2: begin
            if (cyc == 15) begin npulse_i = 2'd1; slot_len_i = 29'd5; end
            else if (cyc == 45) slot_len_i = 29'd1;
         end
         3: begin
            trig_i = (cyc == 5 || cyc == 20 || cyc == 22 || cyc == 45) ? 8'h02 : 8'h00;
            if (cyc == 25) pulse_len_i = '0;
         end
         4: begin
            if (cyc == 15) begin npulse_i = 2'd1; slot_len_i = 29'd5; end
         end
         6: begin
            if (cyc % 50 == 0) begin
               mode_i = 16'($urandom);
               mode_i[1:0] = 2'b10;
               mode_i[5:4] = 2'b10;
            end
            trig_i = 8'($urandom & $urandom);
            if (cyc == 100) begin
               slot_len_i  = 29'($urandom_range(2, 12));
               pulse_len_i = 29'($urandom_range(0, 6));
               npulse_i    = 2'($urandom_range(0, 3));
            end else if (cyc == 200) begin
               slot_len_i  = 29'd1;
               pulse_len_i = 29'($urandom_range(0, 15));
            end
         end
         default: ;
      endcase
   endtask

   task automatic advance();
      model_step();
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_to(input int last);
      while (cyc <= last) begin
         check_now();
         stim();
         advance();
      end
   endtask

   task automatic do_reset(input int scen, input logic [15:0] mode);
      @(negedge clk);
      rst_n = 1'b0;
      cur_scen = scen;
      mode_i = mode; trig_i = '0;
      slot_len_i = 29'd10; pulse_len_i = 29'd3; npulse_i = 2'd3;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_led", led0, 8'h00);
      chk("rst_led_al", led1, 8'hFF);
      chk("rst_tick", tick0, 1'b0);
      rst_n = 1'b1;
      cyc = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: heartbeat ch0, static on ch1, static off ch2
      add(1,0,0,0); add(1,0,8,0); add(1,0,16,1); add(1,0,17,1); add(1,0,18,1);
      add(1,0,1,0); add(1,1,1,1); add(1,5,1,1); add(1,5,17,0); add(1,50,17,0);
      add(1,5,18,1); add(1,50,18,1);
      add(1,10,0,0); add(1,11,0,1); add(1,13,0,1); add(1,14,0,0);
      add(1,21,0,1); add(1,23,0,1); add(1,24,0,0); add(1,31,0,1);
      add(1,33,0,1); add(1,34,0,0); add(1,39,8,0); add(1,40,8,1);
      add(1,41,8,0); add(1,41,0,0); add(1,50,0,0); add(1,51,0,1);
      add(1,53,0,1); add(1,54,0,0); add(1,80,8,1); add(1,81,0,0); add(1,91,0,1);
      // 2: reconfigure at cycle 15, illegal slot length at cycle 45
      add(2,20,8,0); add(2,21,0,1); add(2,23,0,1); add(2,31,0,1); add(2,33,0,1);
      add(2,40,8,1); add(2,45,0,0); add(2,46,0,1); add(2,48,0,1); add(2,49,0,0);
      add(2,52,0,0); add(2,60,8,1); add(2,66,0,1); add(2,68,0,1); add(2,69,0,0);
      add(2,80,8,1);
      // 3: activity ch1 with single, retriggered and zero-length flashes
      add(3,5,1,0); add(3,6,1,1); add(3,9,1,1); add(3,10,1,0);
      add(3,21,1,1); add(3,24,1,1); add(3,26,1,1); add(3,27,1,0);
      add(3,45,1,0); add(3,46,1,1); add(3,47,1,0);
      // 4/5: async reset mid-frame, then defaults restored
      add(4,45,1,1);
      add(5,0,1,0); add(5,10,0,0); add(5,11,0,1); add(5,13,0,1); add(5,14,0,0);
      add(5,20,8,0); add(5,21,0,1); add(5,31,0,1); add(5,40,8,1);

      do_reset(1, 16'h0006);
      run_to(95);

      do_reset(2, 16'h0002);
      run_to(90);

      do_reset(3, 16'h000C);
      run_to(60);

      do_reset(4, 16'h0006);
      run_to(44);
      check_now();
      #2 rst_n = 1'b0;
      #1;
      chk("async_led", led0, 8'h00);
      chk("async_led_al", led1, 8'hFF);
      chk("async_tick", tick0, 1'b0);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
      cur_scen = 5;
      run_to(45);

      do_reset(6, 16'h0022);
      run_to(300);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
